key_cmd_gen: RTL and testbench

KEY_CMD_GEN -- requirements
Module: key_cmd_gen

---
 rtl/key_cmd_gen.sv | 265 ++++++++++++++++++++++++++
 tb/tb_key_cmd_gen.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_gen.sv
// key_cmd_gen: converts the held USB keycode into move/rotate/drop commands with DAS/ARR
// auto-repeat; define KEY_CMD_GRAVITY_EN to add level-scaled gravity commands (cmd=5).

module key_cmd_gen #(
  parameter int         DAS_FRAMES     = 16,
  parameter int         ARR_FRAMES     = 6,
  parameter int         GRAVITY_FRAMES = 48,
  parameter logic [7:0] KEY_LEFT       = 8'h04,
  parameter logic [7:0] KEY_RIGHT      = 8'h07,
  parameter logic [7:0] KEY_ROT        = 8'h1A,
  parameter logic [7:0] KEY_DROP       = 8'h16
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       gamestart,
  input  logic [7:0] keycode,
  input  logic [3:0] level,
  output logic       cmd_valid,
  output logic [2:0] cmd,
  input  logic       cmd_ready,
  output logic       cmd_dropped
);

  localparam logic [2:0] CMD_NONE  = 3'd0;
  localparam logic [2:0] CMD_LEFT  = 3'd1;
  localparam logic [2:0] CMD_RIGHT = 3'd2;
  localparam logic [2:0] CMD_ROT   = 3'd3;
  localparam logic [2:0] CMD_DROP  = 3'd4;
  localparam logic [2:0] CMD_GRAV  = 3'd5;

  localparam logic [7:0] DAS_LAST  = 8'(DAS_FRAMES - 1);
  localparam logic [7:0] ARR_LAST  = 8'(ARR_FRAMES - 1);
  localparam logic [8:0] GRAV_BASE = {1'b0, 8'(GRAVITY_FRAMES)};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FIRST  = 3'd1,
    ST_DAS    = 3'd2,
    ST_REPEAT = 3'd3,
    ST_HOLD   = 3'd4
  } key_state_t;

  // Returns {mapped, command} for a keycode.
  function automatic logic [3:0] map_key(input logic [7:0] code);
    logic [3:0] res;
    res = {1'b0, CMD_NONE};
    if (code == KEY_LEFT) begin
      res = {1'b1, CMD_LEFT};
    end else if (code == KEY_RIGHT) begin
      res = {1'b1, CMD_RIGHT};
    end else if (code == KEY_ROT) begin
      res = {1'b1, CMD_ROT};
    end else if (code == KEY_DROP) begin
      res = {1'b1, CMD_DROP};
    end else begin
      res = {1'b0, CMD_NONE};
    end
    return res;
  endfunction

  logic [2:0] sync_r;
  logic       frame_tick_s;
  key_state_t state_r;
  logic [7:0] key_r;
  logic [7:0] frame_cnt_r;
  logic [3:0] in_map_s;
  logic [3:0] reg_map_s;
  logic       key_chg_s;
  logic       das_hit_s;
  logic       arr_hit_s;
  logic       key_emit_s;
  logic       grav_req_s;
  logic       free_s;
  logic       load_key_s;
  logic       load_grav_s;
  logic       drop_s;
  logic       cmd_valid_r;
  logic [2:0] cmd_r;
  logic       cmd_dropped_r;

  // Two-flop synchronizer for frame_clk plus one history flop for edge detection.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync_r <= 3'b000;
    end else begin
      sync_r <= {sync_r[1:0], frame_clk};
    end
  end

  assign frame_tick_s = sync_r[1] & ~sync_r[2];
  assign in_map_s     = map_key(keycode);
  assign reg_map_s    = map_key(key_r);
  assign key_chg_s    = (keycode != key_r);
  assign das_hit_s    = (frame_cnt_r >= DAS_LAST);
  assign arr_hit_s    = (frame_cnt_r >= ARR_LAST);

  // Key command request; a keycode change in the same cycle pre-empts any emission.
  always_comb begin
    key_emit_s = 1'b0;
    case (state_r)
      ST_FIRST:  key_emit_s = gamestart & ~key_chg_s;
      ST_DAS:    key_emit_s = gamestart & ~key_chg_s & frame_tick_s & das_hit_s;
      ST_REPEAT: key_emit_s = gamestart & ~key_chg_s & frame_tick_s & arr_hit_s;
      default:   key_emit_s = 1'b0;
    endcase
  end

  // Key tracker FSM with shared DAS/ARR frame counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_r     <= ST_IDLE;
      key_r       <= 8'h00;
      frame_cnt_r <= 8'd0;
    end else if (!gamestart) begin
      state_r     <= ST_IDLE;
      key_r       <= 8'h00;
      frame_cnt_r <= 8'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          frame_cnt_r <= 8'd0;
          if (in_map_s[3]) begin
            key_r   <= keycode;
            state_r <= ST_FIRST;
          end else begin
            key_r   <= 8'h00;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          if (key_chg_s) begin
            frame_cnt_r <= 8'd0;
            if (in_map_s[3]) begin
              key_r   <= keycode;
              state_r <= ST_FIRST;
            end else begin
              key_r   <= 8'h00;
              state_r <= ST_IDLE;
            end
          end else begin
            case (state_r)
              ST_FIRST: begin
                frame_cnt_r <= 8'd0;
                state_r     <= (key_r == KEY_ROT) ? ST_HOLD : ST_DAS;
              end
              ST_DAS: begin
                if (frame_tick_s && das_hit_s) begin
                  frame_cnt_r <= 8'd0;
                  state_r     <= ST_REPEAT;
                end else if (frame_tick_s) begin
                  frame_cnt_r <= frame_cnt_r + 8'd1;
                end else begin
                  frame_cnt_r <= frame_cnt_r;
                end
              end
              ST_REPEAT: begin
                if (frame_tick_s && arr_hit_s) begin
                  frame_cnt_r <= 8'd0;
                end else if (frame_tick_s) begin
                  frame_cnt_r <= frame_cnt_r + 8'd1;
                end else begin
                  frame_cnt_r <= frame_cnt_r;
                end
              end
              ST_HOLD: begin
                frame_cnt_r <= 8'd0;
              end
              default: begin
                frame_cnt_r <= 8'd0;
                state_r     <= ST_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

`ifdef KEY_CMD_GRAVITY_EN
  logic [8:0] lvl3_s;
  logic [8:0] grav_period_s;
  logic [7:0] grav_cnt_r;
  logic       grav_hit_s;
  logic       grav_pending_r;

  // Period saturates at 2 frames instead of wrapping at high levels.
  assign lvl3_s        = 9'(level) * 9'd3;
  assign grav_period_s = (GRAV_BASE >= (lvl3_s + 9'd2)) ? (GRAV_BASE - lvl3_s) : 9'd2;
  assign grav_hit_s    = frame_tick_s & (({1'b0, grav_cnt_r} + 9'd1) >= grav_period_s);

  // Gravity frame counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      grav_cnt_r <= 8'd0;
    end else if (!gamestart) begin
      grav_cnt_r <= 8'd0;
    end else if (grav_hit_s) begin
      grav_cnt_r <= 8'd0;
    end else if (frame_tick_s) begin
      grav_cnt_r <= grav_cnt_r + 8'd1;
    end else begin
      grav_cnt_r <= grav_cnt_r;
    end
  end

  // One-deep gravity request; periods that expire while pending merge into it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      grav_pending_r <= 1'b0;
    end else if (!gamestart) begin
      grav_pending_r <= 1'b0;
    end else begin
      grav_pending_r <= (grav_pending_r & ~load_grav_s) | grav_hit_s;
    end
  end

  assign grav_req_s = grav_pending_r;
`else
  logic unused_grav_s;
  assign grav_req_s    = 1'b0;
  assign unused_grav_s = ^{level, GRAV_BASE};
`endif

  // Output slot arbitration: key commands win, gravity waits; keys lost to a busy slot are dropped.
  always_comb begin
    free_s      = ~cmd_valid_r | cmd_ready;
    load_key_s  = free_s & key_emit_s;
    load_grav_s = free_s & ~key_emit_s & grav_req_s;
    drop_s      = ~free_s & key_emit_s;
  end

  // Output register, held until the consumer accepts it.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cmd_valid_r   <= 1'b0;
      cmd_r         <= CMD_NONE;
      cmd_dropped_r <= 1'b0;
    end else if (!gamestart) begin
      cmd_valid_r   <= 1'b0;
      cmd_r         <= CMD_NONE;
      cmd_dropped_r <= 1'b0;
    end else begin
      cmd_dropped_r <= drop_s;
      if (load_key_s) begin
        cmd_valid_r <= 1'b1;
        cmd_r       <= reg_map_s[2:0];
      end else if (load_grav_s) begin
        cmd_valid_r <= 1'b1;
        cmd_r       <= CMD_GRAV;
      end else if (cmd_valid_r && cmd_ready) begin
        cmd_valid_r <= 1'b0;
        cmd_r       <= CMD_NONE;
      end else begin
        cmd_valid_r <= cmd_valid_r;
        cmd_r       <= cmd_r;
      end
    end
  end

  assign cmd_valid   = cmd_valid_r;
  assign cmd         = cmd_r;
  assign cmd_dropped = cmd_dropped_r;

endmodule

// File: tb/tb_key_cmd_gen.sv
// Scoreboard bench for key_cmd_gen: stimulus pushes expected key commands, a monitor pops on handshake.

module tb_key_cmd_gen;

  logic       Clk;
  logic       Reset_n;
  logic       frame_clk;
  logic       gamestart;
  logic [7:0] keycode;
  logic [3:0] level;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       cmd_ready;
  logic       cmd_dropped;

  int n_checks;
  int n_pass;
  int exp_q[$];
  int hist[$];
  int n_key_acc;
  int n_grav_acc;
  int n_drop;
  int base;
  int d0;

  key_cmd_gen dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .frame_clk   (frame_clk),
    .gamestart   (gamestart),
    .keycode     (keycode),
    .level       (level),
    .cmd_valid   (cmd_valid),
    .cmd         (cmd),
    .cmd_ready   (cmd_ready),
    .cmd_dropped (cmd_dropped)
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs and cmd_ready are stable at the falling edge (inputs change just after rising edges).
  always @(negedge Clk) begin
    if (!cmd_valid) check("cmd_zero_when_invalid", int'(cmd), 0);
    if (cmd_dropped) n_drop++;
    if (cmd_valid && cmd_ready) begin
      hist.push_back(int'(cmd));
`ifdef KEY_CMD_GRAVITY_EN
      if (cmd == 3'd5) begin
        n_grav_acc++;
      end else
`endif
      begin
        n_key_acc++;
        if (exp_q.size() == 0) check("unexpected_cmd", int'(cmd), -1);
        else check("sb_cmd", int'(cmd), exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #2;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      tick(10);
      frame_clk = 1'b0;
      tick(10);
    end
  endtask

  task automatic flush();
    keycode   = 8'h00;
    gamestart = 1'b0;
    tick(2);
    gamestart = 1'b1;
    tick(2);
  endtask

  // After an input change driven just past a rising edge: invalid after one edge, valid with cmd after two.
  task automatic check_latency(input string name, input int exp_cmd);
    @(posedge Clk);
    @(negedge Clk);
    check({name, "_not_yet"}, int'(cmd_valid), 0);
    @(posedge Clk);
    @(negedge Clk);
    check({name, "_valid"}, int'(cmd_valid), 1);
    check({name, "_cmd"}, int'(cmd), exp_cmd);
    @(posedge Clk);
    #2;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; n_key_acc = 0; n_grav_acc = 0; n_drop = 0;
    Reset_n = 1'b0; frame_clk = 1'b0; gamestart = 1'b0; keycode = 8'h00;
    level = 4'd0; cmd_ready = 1'b1;
    tick(3);
    check("reset_valid", int'(cmd_valid), 0);
    check("reset_cmd", int'(cmd), 0);
    check("reset_dropped", int'(cmd_dropped), 0);
    Reset_n = 1'b1;
    tick(2);
    gamestart = 1'b1;
    tick(2);

    // Left held: first command after 2 cycles, repeat at 16th tick, then every 6th.
    flush();
    base = n_key_acc;
    exp_q.push_back(1);
    keycode = 8'h04;
    check_latency("left_press", 1);
    frames(15);
    check("das_before_16", n_key_acc, base + 1);
    exp_q.push_back(1);
    frames(1);
    check("das_at_16", n_key_acc, base + 2);
    frames(5);
    check("arr_before_6", n_key_acc, base + 2);
    exp_q.push_back(1);
    frames(1);
    check("arr_at_6", n_key_acc, base + 3);
    exp_q.push_back(1);
    frames(6);
    check("arr_second", n_key_acc, base + 4);
    keycode = 8'h00;
    tick(5);

    // Rotate held 100 frames: exactly one command.
    flush();
    base = n_key_acc;
    exp_q.push_back(3);
    keycode = 8'h1A;
    frames(100);
    check("rot_single", n_key_acc, base + 1);
    keycode = 8'h00;
    tick(5);

    // Consumer stalled: first command held, second press dropped with one pulse.
    flush();
    base = n_key_acc;
    cmd_ready = 1'b0;
    keycode = 8'h04;
    tick(3);
    check("stall_valid", int'(cmd_valid), 1);
    check("stall_cmd", int'(cmd), 1);
    d0 = n_drop;
    keycode = 8'h07;
    tick(4);
    check("stall_hold_valid", int'(cmd_valid), 1);
    check("stall_hold_cmd", int'(cmd), 1);
    check("drop_pulse", n_drop, d0 + 1);
    frames(2);
    check("stall_hold_cmd_late", int'(cmd), 1);
    check("drop_single", n_drop, d0 + 1);
    keycode = 8'h00;
    tick(2);
    exp_q.push_back(1);
    cmd_ready = 1'b1;
    tick(3);
    check("stall_release", n_key_acc, base + 1);

    // gamestart low during REPEAT with a held command.
    flush();
    base = n_key_acc;
    exp_q.push_back(1);
    exp_q.push_back(1);
    keycode = 8'h04;
    frames(16);
    cmd_ready = 1'b0;
    frames(6);
    check("rep_held_cmd", int'(cmd), 1);
    gamestart = 1'b0;
    @(negedge Clk);
    check("gs_pre_valid", int'(cmd_valid), 1);
    @(posedge Clk);
    @(negedge Clk);
    check("gs_low_valid", int'(cmd_valid), 0);
    check("gs_low_cmd", int'(cmd), 0);
    @(posedge Clk);
    #2;
    cmd_ready = 1'b1;
    frames(3);
    check("gs_low_silent", n_key_acc, base + 2);
    exp_q.push_back(1);
    gamestart = 1'b1;
    check_latency("gs_restart", 1);
    keycode = 8'h00;
    tick(5);

    // Reset mid-DAS with a held command, release with right held.
    flush();
    cmd_ready = 1'b0;
    keycode = 8'h07;
    tick(3);
    check("pre_rst_cmd", int'(cmd), 2);
    frames(5);
    Reset_n = 1'b0;
    #1;
    check("rst_async_valid", int'(cmd_valid), 0);
    check("rst_async_cmd", int'(cmd), 0);
    check("rst_async_drop", int'(cmd_dropped), 0);
    tick(3);
    cmd_ready = 1'b1;
    exp_q.push_back(2);
    Reset_n = 1'b1;
    check_latency("rst_release", 2);
    keycode = 8'h00;
    tick(5);

`ifdef KEY_CMD_GRAVITY_EN
    // Gravity period at level 5 (33) and level 15 (3).
    level = 4'd5;
    flush();
    base = n_grav_acc;
    frames(32);
    check("grav5_early", n_grav_acc, base);
    frames(1);
    check("grav5_first", n_grav_acc, base + 1);
    frames(33);
    check("grav5_second", n_grav_acc, base + 2);
    level = 4'd15;
    flush();
    base = n_grav_acc;
    frames(2);
    check("grav15_early", n_grav_acc, base);
    frames(1);
    check("grav15_first", n_grav_acc, base + 1);
    frames(3);
    check("grav15_second", n_grav_acc, base + 2);

    // Key and pending gravity compete for the same free slot: key first.
    flush();
    cmd_ready = 1'b0;
    exp_q.push_back(1);
    keycode = 8'h04;
    tick(3);
    frames(3);
    exp_q.push_back(2);
    keycode = 8'h07;
    @(posedge Clk);
    #2;
    cmd_ready = 1'b1;
    tick(5);
    check("prio_len", (hist.size() >= 3) ? 1 : 0, 1);
    check("prio_0", hist[hist.size() - 3], 1);
    check("prio_1", hist[hist.size() - 2], 2);
    check("prio_2", hist[hist.size() - 1], 5);
    keycode = 8'h00;
    tick(5);
`else
    // Without gravity, no command appears from level or elapsed frames alone.
    level = 4'd15;
    flush();
    base = n_key_acc;
    frames(10);
    check("no_gravity", n_key_acc, base);
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
